// File: rtl/fb_scanout_if.sv
// Drawing-side bus of the frame-buffer scan-out block: pixel writes, the clear
// handshake and the VGA outputs, grouped so the producer and display share one bundle.
interface fb_scanout_if;
  logic       wr_en;
  logic [9:0] x;
  logic [8:0] y;
  logic       pixel_color;
  logic       clear_req;
  logic       busy;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_pixel;
  logic       frame_start;

  modport master (
    output wr_en, x, y, pixel_color, clear_req,
    input  busy, vga_hs, vga_vs, vga_blank_n, vga_pixel, frame_start
  );

  modport slave (
    input  wr_en, x, y, pixel_color, clear_req,
    output busy, vga_hs, vga_vs, vga_blank_n, vga_pixel, frame_start
  );
endinterface

// File: rtl/fb_scanout.sv
// 1-bpp frame buffer with single-pixel writes, a sequential clear engine and
// continuous VGA scan-out paced by a pixel-tick enable on the single system clock.
module fb_scanout #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  fb_scanout_if.slave  bus
);
  localparam int H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int MEM_DEPTH = H_VIS * V_VIS;
  localparam int AW        = $clog2(MEM_DEPTH);
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS_C   = 10'(H_VIS);
  localparam logic [9:0]    V_VIS_C   = 10'(V_VIS);
  localparam logic [9:0]    HS_BEG    = 10'(H_VIS + H_FP);
  localparam logic [9:0]    HS_END    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]    VS_BEG    = 10'(V_VIS + V_FP);
  localparam logic [9:0]    VS_END    = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [8:0]    V_VIS_Y   = 9'(V_VIS);
  localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0] H_VIS_A   = AW'(H_VIS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [DW-1:0] div;
  logic          tick;
  logic [9:0]    hcnt, vcnt;
  logic          hs_raw, vs_raw, vis;
  logic [AW-1:0] rd_addr, wr_addr, clr_addr, mem_a;
  logic          wr_ok, mem_we, mem_wd, mem_q;
  logic [0:0]    state;
  logic          mem [MEM_DEPTH];

  assign tick = (div == DIV_MAX);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) div <= '0;
    else       div <= tick ? '0 : div + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt            <= '0;
      vcnt            <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= tick && (hcnt == H_LAST) && (vcnt == V_LAST);
      if (tick) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  assign hs_raw  = !((hcnt >= HS_BEG) && (hcnt < HS_END));
  assign vs_raw  = !((vcnt >= VS_BEG) && (vcnt < VS_END));
  assign vis     = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
  // Off-screen positions read address 0 so the index never leaves the array.
  assign rd_addr = vis ? AW'(AW'(vcnt) * H_VIS_A + AW'(hcnt)) : '0;

  // Sync and blank are delayed one tick to line up with the registered memory read.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.vga_hs      <= 1'b1;
      bus.vga_vs      <= 1'b1;
      bus.vga_blank_n <= 1'b0;
    end else if (tick) begin
      bus.vga_hs      <= hs_raw;
      bus.vga_vs      <= vs_raw;
      bus.vga_blank_n <= vis;
    end
  end

  assign bus.vga_pixel = mem_q & bus.vga_blank_n;

  assign wr_ok   = bus.wr_en && (bus.x < H_VIS_C) && (bus.y < V_VIS_Y);
  assign wr_addr = AW'(AW'(bus.y) * H_VIS_A + AW'(bus.x));
  assign bus.busy = (state == S_CLEAR);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = wr_addr;
    mem_wd = bus.pixel_color;
    if (!reset) begin
      if (state == S_CLEAR) begin
        mem_we = 1'b1;
        mem_a  = clr_addr;
        mem_wd = 1'b0;
      end else if (wr_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      clr_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.clear_req) begin
          state    <= S_CLEAR;
          clr_addr <= '0;
        end
        S_CLEAR: begin
          if (clr_addr == LAST_ADDR) state    <= S_IDLE;
          else                       clr_addr <= clr_addr + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the pixel array has no reset; clearing it is the job of the clear engine.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
  end

  // Separate read process: a same-cycle write to the scanned address returns the old bit.
  always_ff @(posedge clk) begin
    if (tick) mem_q <= mem[rd_addr];
  end
endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout on a reduced raster; expected outputs come from
// a time-indexed raster model plus a shadow copy of the frame buffer.
module tb_fb_scanout;
  localparam int HV = 16, HF = 2, HS = 4, HB = 2;
  localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
  localparam int CD = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int FRAME_CLK = FRAME * CD;
  localparam int N = HV * VV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  fb_scanout_if bus();

  fb_scanout #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(CD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n = 0;
  int disp_p = -1;
  bit model_mem [N];
  bit known [N];
  bit m_busy = 1'b0;
  int m_clr = 0;
  bit e_hs = 1'b1, e_vs = 1'b1, e_blank = 1'b0, e_pix = 1'b0, e_pk = 1'b1, e_fs = 1'b0;
  logic [5:0] exp_v, care;

  function automatic logic [5:0] observe();
    return {bus.busy, bus.vga_hs, bus.vga_vs, bus.vga_blank_n, bus.vga_pixel, bus.frame_start};
  endfunction

  // Advance one clock: the model derives the displayed raster position from the number
  // of ticks since reset, then applies this edge's buffer update (clear before write).
  task automatic step();
    @(posedge clk);
    cyc++;
    if (reset) begin
      n = 0; m_busy = 0; disp_p = -1;
      e_hs = 1; e_vs = 1; e_blank = 0; e_pix = 0; e_pk = 1; e_fs = 0;
    end else begin
      n++;
      e_fs = 0;
      if (n % CD == 0) begin
        int t, p, h, v;
        t = n / CD;
        p = (t - 1) % FRAME;
        h = p % HT;
        v = p / HT;
        disp_p  = p;
        e_hs    = !(h >= HV + HF && h < HV + HF + HS);
        e_vs    = !(v >= VV + VF && v < VV + VF + VS);
        e_blank = (h < HV) && (v < VV);
        if (e_blank) begin
          e_pix = model_mem[v * HV + h];
          e_pk  = known[v * HV + h];
        end else begin
          e_pix = 0;
          e_pk  = 1;
        end
        e_fs = (t % FRAME == 0);
      end
      if (m_busy) begin
        model_mem[m_clr] = 0;
        known[m_clr] = 1;
        m_clr++;
        if (m_clr == N) m_busy = 0;
      end else begin
        if (bus.wr_en && bus.x < HV && bus.y < VV) begin
          model_mem[int'(bus.y) * HV + int'(bus.x)] = bus.pixel_color;
          known[int'(bus.y) * HV + int'(bus.x)] = 1;
        end
        if (bus.clear_req) begin
          m_busy = 1;
          m_clr = 0;
        end
      end
    end
    exp_v = {m_busy, e_hs, e_vs, e_blank, e_pix, e_fs};
    care  = e_pk ? 6'b111111 : 6'b111101;
    @(negedge clk);
  endtask

  task automatic set_write(input bit en, input int xx, input int yy, input bit c);
    bus.wr_en = en;
    bus.x = 10'(xx);
    bus.y = 9'(yy);
    bus.pixel_color = c;
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    step();
    checks++;
    if (observe() !== 6'b011000) begin
      errors++; $display("FAIL reset_outputs got=%b want=011000", observe());
    end
    reset = 0;
    step();
    checks++;
    if (observe() !== 6'b011000) begin
      errors++; $display("FAIL reset_first_cycle got=%b want=011000", observe());
    end
  endtask

  task automatic test_fill_clear();
    int busy_cnt = 0;
    int lit = 0;
    for (int yy = 0; yy < VV; yy++)
      for (int xx = 0; xx < HV; xx++) begin
        set_write(1, xx, yy, 1);
        step();
        checks++;
        if (((observe() ^ exp_v) & care) != 6'd0) begin
          errors++; $display("FAIL fill cyc=%0d got=%b want=%b", cyc, observe(), exp_v);
        end
      end
    set_write(0, 0, 0, 0);
    bus.clear_req = 1;
    step();
    bus.clear_req = 0;
    for (int i = 0; i < N + 10 && bus.busy === 1'b1; i++) begin
      busy_cnt++;
      set_write(1, 3, 3, 1);
      step();
      checks++;
      if (((observe() ^ exp_v) & care) != 6'd0) begin
        errors++; $display("FAIL clear cyc=%0d got=%b want=%b", cyc, observe(), exp_v);
      end
    end
    set_write(0, 0, 0, 0);
    checks++;
    if (busy_cnt != N) begin
      errors++; $display("FAIL clear_busy_len got=%0d want=%0d", busy_cnt, N);
    end
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      checks++;
      if (((observe() ^ exp_v) & care) != 6'd0) begin
        errors++; $display("FAIL after_clear cyc=%0d got=%b want=%b", cyc, observe(), exp_v);
      end
      if (bus.vga_pixel === 1'b1) lit++;
    end
    checks++;
    if (lit != 0) begin
      errors++; $display("FAIL clear_frame_lit got=%0d want=0", lit);
    end
  endtask

  task automatic test_timing();
    logic p_hs, p_vs, p_bl, p_fs;
    int hs_f = -1, vs_f = -1, fs_t = -1, bl_r = -1, n_vs = 0, n_fs = 0, n_bl = 0;
    p_hs = bus.vga_hs; p_vs = bus.vga_vs; p_bl = bus.vga_blank_n; p_fs = bus.frame_start;
    for (int i = 0; i < 2 * FRAME_CLK + HT * CD; i++) begin
      step();
      checks++;
      if (((observe() ^ exp_v) & care) != 6'd0) begin
        errors++; $display("FAIL timing cyc=%0d got=%b want=%b", cyc, observe(), exp_v);
      end
      if (p_hs && !bus.vga_hs) begin
        if (hs_f >= 0) begin
          checks++;
          if (cyc - hs_f != HT * CD) begin
            errors++; $display("FAIL hs_period got=%0d want=%0d", cyc - hs_f, HT * CD);
          end
        end
        hs_f = cyc;
      end
      if (!p_hs && bus.vga_hs && hs_f >= 0) begin
        checks++;
        if (cyc - hs_f != HS * CD) begin
          errors++; $display("FAIL hs_low got=%0d want=%0d", cyc - hs_f, HS * CD);
        end
      end
      if (p_vs && !bus.vga_vs) begin
        if (vs_f >= 0) begin
          checks++; n_vs++;
          if (cyc - vs_f != FRAME_CLK) begin
            errors++; $display("FAIL vs_period got=%0d want=%0d", cyc - vs_f, FRAME_CLK);
          end
        end
        vs_f = cyc;
      end
      if (!p_vs && bus.vga_vs && vs_f >= 0) begin
        checks++;
        if (cyc - vs_f != VS * HT * CD) begin
          errors++; $display("FAIL vs_low got=%0d want=%0d", cyc - vs_f, VS * HT * CD);
        end
      end
      if (!p_fs && bus.frame_start) begin
        if (fs_t >= 0) begin
          checks++; n_fs++;
          if (cyc - fs_t != FRAME_CLK) begin
            errors++; $display("FAIL fs_period got=%0d want=%0d", cyc - fs_t, FRAME_CLK);
          end
        end
        fs_t = cyc;
      end
      if (!p_bl && bus.vga_blank_n) bl_r = cyc;
      if (p_bl && !bus.vga_blank_n && bl_r >= 0) begin
        checks++; n_bl++;
        if (cyc - bl_r != HV * CD) begin
          errors++; $display("FAIL blank_width got=%0d want=%0d", cyc - bl_r, HV * CD);
        end
      end
      p_hs = bus.vga_hs; p_vs = bus.vga_vs; p_bl = bus.vga_blank_n; p_fs = bus.frame_start;
    end
    checks++;
    if (n_vs < 1 || n_fs < 1 || n_bl < 2 * VV - 1) begin
      errors++; $display("FAIL timing_events vs=%0d fs=%0d blank_lines=%0d", n_vs, n_fs, n_bl);
    end
  endtask

  task automatic test_single_pixel();
    bit found = 0;
    logic p_bl;
    int line = 0, bl_r = -1, lit = 0, lit_line = -1, lit_off = -1;
    set_write(1, 5, 3, 1);
    step();
    set_write(0, 0, 0, 0);
    for (int i = 0; i < FRAME_CLK + 4; i++) begin
      step();
      checks++;
      if (((observe() ^ exp_v) & care) != 6'd0) begin
        errors++; $display("FAIL single_sync cyc=%0d got=%b want=%b", cyc, observe(), exp_v);
      end
      if (bus.frame_start === 1'b1) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL single_frame_start got=none want=pulse");
    end
    p_bl = bus.vga_blank_n;
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      checks++;
      if (((observe() ^ exp_v) & care) != 6'd0) begin
        errors++; $display("FAIL single_scan cyc=%0d got=%b want=%b", cyc, observe(), exp_v);
      end
      if (!p_bl && bus.vga_blank_n) begin line++; bl_r = cyc; end
      if (bus.vga_pixel === 1'b1) begin
        if (lit == 0) begin lit_line = line - 1; lit_off = cyc - bl_r; end
        lit++;
      end
      p_bl = bus.vga_blank_n;
    end
    checks++;
    if (lit != CD || lit_line != 3 || lit_off != 5 * CD) begin
      errors++;
      $display("FAIL single_pixel got lit=%0d line=%0d off=%0d want lit=%0d line=3 off=%0d",
               lit, lit_line, lit_off, CD, 5 * CD);
    end
  endtask

  task automatic test_out_of_range();
    int lit = 0;
    set_write(1, 5, 3, 0);
    step();
    set_write(1, HV, 0, 1);
    step();
    set_write(1, 0, VV, 1);
    step();
    set_write(0, 0, 0, 0);
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      checks++;
      if (((observe() ^ exp_v) & care) != 6'd0) begin
        errors++; $display("FAIL oor_scan cyc=%0d got=%b want=%b", cyc, observe(), exp_v);
      end
      if (bus.vga_pixel === 1'b1) lit++;
    end
    checks++;
    if (lit != 0) begin
      errors++; $display("FAIL oor_lit got=%0d want=0", lit);
    end
  endtask

  task automatic test_random_writes();
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      set_write($urandom_range(3) == 0, $urandom_range(HV + 1), $urandom_range(VV + 1),
                $urandom_range(1) == 1);
      step();
      checks++;
      if (((observe() ^ exp_v) & care) != 6'd0) begin
        errors++; $display("FAIL random cyc=%0d got=%b want=%b", cyc, observe(), exp_v);
      end
    end
    set_write(0, 0, 0, 0);
  endtask

  task automatic test_collision();
    localparam int P = 2 * HT + 7;
    bit found = 0;
    set_write(1, 7, 2, 0);
    step();
    set_write(0, 0, 0, 0);
    for (int i = 0; i < FRAME_CLK + 4; i++) begin
      if ((n + 1) % CD == 0 && (((n + 1) / CD - 1) % FRAME) == P) begin found = 1; break; end
      step();
      checks++;
      if (((observe() ^ exp_v) & care) != 6'd0) begin
        errors++; $display("FAIL coll_wait cyc=%0d got=%b want=%b", cyc, observe(), exp_v);
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL coll_align got=none want=scan slot");
    end
    set_write(1, 7, 2, 1);
    step();
    set_write(0, 0, 0, 0);
    checks++;
    if (bus.vga_pixel !== 1'b0 || bus.vga_blank_n !== 1'b1) begin
      errors++; $display("FAIL coll_old got=%b%b want=10", bus.vga_blank_n, bus.vga_pixel);
    end
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      checks++;
      if (((observe() ^ exp_v) & care) != 6'd0) begin
        errors++; $display("FAIL coll_scan cyc=%0d got=%b want=%b", cyc, observe(), exp_v);
      end
    end
    checks++;
    if (bus.vga_pixel !== 1'b1) begin
      errors++; $display("FAIL coll_new got=%b want=1", bus.vga_pixel);
    end
  endtask

  task automatic test_reset_mid_clear();
    localparam int K = 40;
    localparam int P_CLR = 2 * HT + 7;
    localparam int P_KEEP = 6 * HT + 4;
    bit seen_c = 0, seen_k = 0;
    logic got_c = 1'b1, got_k = 1'b0;
    for (int a = 0; a < N; a++) begin
      set_write(1, a % HV, a / HV, 1);
      step();
    end
    set_write(0, 0, 0, 0);
    bus.clear_req = 1;
    step();
    bus.clear_req = 0;
    for (int i = 0; i < K; i++) step();
    reset = 1;
    step();
    reset = 0;
    checks++;
    if (observe() !== 6'b011000) begin
      errors++; $display("FAIL midclear_reset got=%b want=011000", observe());
    end
    for (int i = 0; i < FRAME_CLK + CD; i++) begin
      step();
      checks++;
      if (((observe() ^ exp_v) & care) != 6'd0) begin
        errors++; $display("FAIL midclear_scan cyc=%0d got=%b want=%b", cyc, observe(), exp_v);
      end
      if (n % CD == 0 && disp_p == P_CLR && !seen_c) begin seen_c = 1; got_c = bus.vga_pixel; end
      if (n % CD == 0 && disp_p == P_KEEP && !seen_k) begin seen_k = 1; got_k = bus.vga_pixel; end
    end
    checks++;
    if (!seen_c || got_c !== 1'b0) begin
      errors++; $display("FAIL midclear_cleared got=%b want=0", got_c);
    end
    checks++;
    if (!seen_k || got_k !== 1'b1) begin
      errors++; $display("FAIL midclear_kept got=%b want=1", got_k);
    end
  endtask

  initial begin
    set_write(0, 0, 0, 0);
    bus.clear_req = 0;
    test_reset();
    test_fill_clear();
    test_timing();
    test_single_pixel();
    test_out_of_range();
    test_random_writes();
    test_collision();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
